// File: rtl/mag_line_tracker.sv
// mag_line_tracker: debounced magnetic line sensors driving a registered direction command with lost-line search
module mag_line_tracker #(
  parameter int NUM_SENS     = 4,
  parameter int DEBOUNCE     = 12_500_000,
  parameter int CNT_W        = 24,
  parameter int ACTIVE_LOW   = 1,
  parameter int LOST_TIMEOUT = 25_000_000,
  parameter int LOST_W       = 25
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_SENS-1:0] sens_raw,
  output logic [NUM_SENS-1:0] sens_stable,
  output logic                sens_chg,
  output logic [3:0]          dir,
  output logic                lost
);
  localparam logic [NUM_SENS-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? {NUM_SENS{1'b1}} : {NUM_SENS{1'b0}};
  localparam logic [CNT_W-1:0] DB_END = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DB_MAX = {CNT_W{1'b1}};
  localparam logic [LOST_W-1:0] LOST_END = LOST_W'(LOST_TIMEOUT - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] STOP  = 2'd2;
  localparam logic [1:0] LOST  = 2'd3;
  localparam logic [3:0] D_FWD    = 4'b0000;
  localparam logic [3:0] D_VEER_L = 4'b0101;
  localparam logic [3:0] D_VEER_R = 4'b1001;
  localparam logic [3:0] D_STOP   = 4'b1111;
  localparam logic [3:0] D_SEARCH = 4'b0110;

  logic [NUM_SENS-1:0] s1, s2, sn, upd;
  logic [CNT_W-1:0]    cnt [NUM_SENS];
  logic [LOST_W-1:0]   lcnt;
  logic [1:0]          state, nxt;
  logic [1:0]          front;
  logic                any_on;
  logic [3:0]          dir_n;

  // Two-flop synchroniser followed by a registered active-high normalisation stage
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= IDLE_RAW;
      s2 <= IDLE_RAW;
      sn <= '0;
    end else begin
      s1 <= sens_raw;
      s2 <= s1;
      sn <= s2 ^ IDLE_RAW;
    end
  end

  for (genvar c = 0; c < NUM_SENS; c++) begin : g_db
    assign upd[c] = (sn[c] != sens_stable[c]) && (cnt[c] == DB_END);
    // Count consecutive cycles of disagreement; any agreement restarts the count
    always_ff @(posedge clock) begin
      if (reset || sn[c] == sens_stable[c] || upd[c]) cnt[c] <= '0;
      else if (cnt[c] != DB_MAX) cnt[c] <= cnt[c] + CNT_W'(1);
    end
  end

  // Accept debounced levels; one change pulse covers all channels flipping together
  always_ff @(posedge clock) begin
    if (reset) begin
      sens_stable <= '0;
      sens_chg    <= 1'b0;
    end else begin
      sens_stable <= sens_stable ^ upd;
      sens_chg    <= |upd;
    end
  end

  assign front  = sens_stable[1:0];
  assign any_on = |sens_stable;

  // Next state and the direction it implies; rear channels only feed any_on
  always_comb begin
    nxt = !enable ? IDLE :
          state == IDLE  ? TRACK :
          state == TRACK ? (front == 2'b11 ? STOP : (!any_on && lcnt == LOST_END) ? LOST : TRACK) :
          state == STOP  ? (front != 2'b11 ? TRACK : STOP) :
          (any_on ? TRACK : LOST);
    dir_n = nxt == LOST ? D_SEARCH :
            nxt != TRACK ? D_STOP :
            front == 2'b01 ? D_VEER_L :
            front == 2'b10 ? D_VEER_R :
            front == 2'b11 ? D_STOP : D_FWD;
  end

  // State and outputs registered together so dir/lost follow the state entered on this edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      dir   <= D_STOP;
      lost  <= 1'b0;
    end else begin
      state <= nxt;
      dir   <= dir_n;
      lost  <= nxt == LOST;
    end
  end

  // Lost-line timer runs only while tracking with every sensor inactive
  always_ff @(posedge clock) begin
    if (reset || state != TRACK || nxt != TRACK || any_on) lcnt <= '0;
    else lcnt <= lcnt + LOST_W'(1);
  end
endmodule

// File: tb/tb_mag_line_tracker.sv
// tb_mag_line_tracker: directed checks of debounce, direction decode, lost timeout, enable and reset
module tb_mag_line_tracker;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] sens_raw = 4'b1111;
  logic [3:0] sens_stable;
  logic       sens_chg;
  logic [3:0] dir;
  logic       lost;
  int checks = 0;
  int failures = 0;

  mag_line_tracker #(
    .NUM_SENS(4), .DEBOUNCE(4), .CNT_W(3), .ACTIVE_LOW(1), .LOST_TIMEOUT(8), .LOST_W(4)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .sens_raw(sens_raw),
    .sens_stable(sens_stable), .sens_chg(sens_chg), .dir(dir), .lost(lost)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    tick(2);
    chk("rst_stable", sens_stable, 4'b0000);
    chk("rst_chg", {3'b0, sens_chg}, 4'b0000);
    chk("rst_dir", dir, 4'b1111);
    chk("rst_lost", {3'b0, lost}, 4'b0000);
    reset = 1'b0;
    tick(2);
    chk("idle_dir", dir, 4'b1111);
    chk("idle_lost", {3'b0, lost}, 4'b0000);
    sens_raw = 4'b1110;
    tick(3);
    sens_raw = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch_chg", {3'b0, sens_chg}, 4'b0000);
      chk("glitch_stable", sens_stable, 4'b0000);
    end
    chk("glitch_idle_dir", dir, 4'b1111);
    sens_raw = 4'b1110;
    enable = 1'b1;
    tick(1);
    chk("track_fwd", dir, 4'b0000);
    tick(5);
    chk("rf_early", sens_stable, 4'b0000);
    tick(1);
    chk("rf_stable", sens_stable, 4'b0001);
    chk("rf_chg", {3'b0, sens_chg}, 4'b0001);
    chk("rf_dir_lag", dir, 4'b0000);
    tick(1);
    chk("veer_l", dir, 4'b0101);
    chk("rf_chg_end", {3'b0, sens_chg}, 4'b0000);
    chk("veer_l_lost", {3'b0, lost}, 4'b0000);
    sens_raw = 4'b1100;
    tick(6);
    chk("both_early", sens_stable, 4'b0001);
    tick(1);
    chk("both_stable", sens_stable, 4'b0011);
    chk("both_chg", {3'b0, sens_chg}, 4'b0001);
    tick(1);
    chk("stop_dir", dir, 4'b1111);
    sens_raw = 4'b1111;
    tick(6);
    chk("stop_hold", dir, 4'b1111);
    tick(1);
    chk("clear_stable", sens_stable, 4'b0000);
    chk("clear_chg", {3'b0, sens_chg}, 4'b0001);
    tick(1);
    chk("stop_to_fwd", dir, 4'b0000);
    tick(7);
    chk("lost_early", {3'b0, lost}, 4'b0000);
    chk("lost_early_dir", dir, 4'b0000);
    tick(1);
    chk("lost_set", {3'b0, lost}, 4'b0001);
    chk("search_dir", dir, 4'b0110);
    sens_raw = 4'b0111;
    tick(7);
    chk("rear_stable", sens_stable, 4'b1000);
    chk("rear_lost_hold", {3'b0, lost}, 4'b0001);
    tick(1);
    chk("found_lost", {3'b0, lost}, 4'b0000);
    chk("found_dir", dir, 4'b0000);
    sens_raw = 4'b1111;
    tick(7);
    chk("rear_clear", sens_stable, 4'b0000);
    tick(7);
    chk("relost_early", {3'b0, lost}, 4'b0000);
    tick(1);
    chk("relost_set", {3'b0, lost}, 4'b0001);
    enable = 1'b0;
    tick(1);
    chk("dis_lost", {3'b0, lost}, 4'b0000);
    chk("dis_dir", dir, 4'b1111);
    tick(1);
    chk("dis_dir_hold", dir, 4'b1111);
    enable = 1'b1;
    tick(1);
    chk("reen_dir", dir, 4'b0000);
    chk("reen_lost", {3'b0, lost}, 4'b0000);
    sens_raw = 4'b1110;
    tick(5);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_stable", sens_stable, 4'b0000);
    chk("mid_rst_dir", dir, 4'b1111);
    chk("mid_rst_chg", {3'b0, sens_chg}, 4'b0000);
    chk("mid_rst_lost", {3'b0, lost}, 4'b0000);
    reset = 1'b0;
    tick(6);
    chk("post_rst_early", sens_stable, 4'b0000);
    chk("post_rst_chg", {3'b0, sens_chg}, 4'b0000);
    tick(1);
    chk("post_rst_stable", sens_stable, 4'b0001);
    chk("post_rst_pulse", {3'b0, sens_chg}, 4'b0001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
